// File: rtl/cache_burst_adapter.sv
// Splits the cache's burst Avalon master traffic into single-word transactions.
// Reads are pipelined with a bounded number outstanding; write beats are re-addressed one by one.
module cache_burst_adapter #(
    parameter int BURST_W     = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        s0_address,
    input  logic [3:0]         s0_byteEnable,
    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [31:0]        s0_writeData,
    input  logic               s0_beginBurstTransfer,
    input  logic [BURST_W-1:0] s0_burstCount,
    output logic               s0_waitRequest,
    output logic [31:0]        s0_readData,
    output logic               s0_readDataValid,
    output logic [31:0]        m0_address,
    output logic [3:0]         m0_byteEnable,
    output logic               m0_read,
    output logic               m0_write,
    output logic [31:0]        m0_writeData,
    input  logic               m0_waitRequest,
    input  logic [31:0]        m0_readData,
    input  logic               m0_readDataValid
);
    localparam int            CW       = BURST_W + 1;
    localparam logic [3:0]    PEND_MAX = 4'(MAX_PENDING);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state, state_next;
    logic [31:0]   base;
    logic [CW-1:0] total, issued, returned, beat;
    logic [3:0]    pending;

    logic [CW-1:0] req_count, issued_next;
    logic [3:0]    pending_next;
    logic [31:0]   new_base, rd_addr, wr_addr;
    logic          rd_accept, wr_accept, rd_load, rd_hs, rd_ret;
    logic          unused_inputs;

    assign unused_inputs = ^{s0_beginBurstTransfer, s0_address[1:0]};

    assign req_count    = (s0_burstCount == '0) ? ONE : CW'(s0_burstCount);
    assign new_base     = {s0_address[31:2], 2'b00};
    assign rd_hs        = m0_read & ~m0_waitRequest;
    // Data arriving with nothing outstanding is stale (e.g. from before a reset) and is dropped.
    assign rd_ret       = m0_readDataValid & (pending != 4'd0);
    assign issued_next  = issued + CW'(rd_hs);
    assign pending_next = pending + {3'b000, rd_hs} - {3'b000, rd_ret};
    assign rd_addr      = base + (32'(issued_next) << 2);
    assign wr_addr      = base + (32'(beat) << 2);

    always_comb begin
        if (!rest) begin
            s0_waitRequest = 1'b1;
        end else if (state == RD) begin
            s0_waitRequest = 1'b1;
        end else begin
            s0_waitRequest = m0_write & m0_waitRequest;
        end
    end

    // A new read is only launched if, once accepted, it still fits within the outstanding limit.
    always_comb begin
        state_next = state;
        rd_accept  = 1'b0;
        wr_accept  = 1'b0;
        rd_load    = 1'b0;
        case (state)
            IDLE: begin
                if (s0_read && !s0_waitRequest) begin
                    rd_accept  = 1'b1;
                    rd_load    = (pending_next < PEND_MAX);
                    state_next = RD;
                end else if (s0_write && !s0_waitRequest) begin
                    wr_accept = 1'b1;
                    if (req_count != ONE) begin
                        state_next = WR;
                    end
                end
            end
            RD: begin
                if (returned == total) begin
                    state_next = IDLE;
                end else if (!(m0_read && m0_waitRequest)) begin
                    rd_load = (issued_next < total) && (pending_next < PEND_MAX);
                end
            end
            WR: begin
                if (s0_write && !s0_waitRequest) begin
                    wr_accept = 1'b1;
                    if ((beat + ONE) == total) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            base             <= '0;
            total            <= '0;
            issued           <= '0;
            returned         <= '0;
            beat             <= '0;
            pending          <= '0;
            s0_readData      <= '0;
            s0_readDataValid <= 1'b0;
        end else begin
            pending          <= pending_next;
            s0_readDataValid <= rd_ret;
            if (rd_ret) begin
                s0_readData <= m0_readData;
            end
            if (rd_accept) begin
                base     <= new_base;
                total    <= req_count;
                issued   <= '0;
                returned <= '0;
            end else begin
                issued <= issued_next;
                if (rd_ret) begin
                    returned <= returned + ONE;
                end
                if (wr_accept && state == IDLE) begin
                    base  <= new_base;
                    total <= req_count;
                    beat  <= ONE;
                end else if (wr_accept) begin
                    beat <= beat + ONE;
                end
            end
        end
    end

    // A request stalled by the slave is held; otherwise the register is reloaded or cleared each cycle.
    always_ff @(posedge clk) begin
        if (!rest) begin
            m0_read       <= 1'b0;
            m0_write      <= 1'b0;
            m0_address    <= '0;
            m0_byteEnable <= '0;
            m0_writeData  <= '0;
        end else if (rd_load) begin
            m0_read       <= 1'b1;
            m0_write      <= 1'b0;
            m0_address    <= (state == IDLE) ? new_base : rd_addr;
            m0_byteEnable <= 4'hF;
        end else if (wr_accept) begin
            m0_read       <= 1'b0;
            m0_write      <= 1'b1;
            m0_address    <= (state == IDLE) ? new_base : wr_addr;
            m0_writeData  <= s0_writeData;
            m0_byteEnable <= s0_byteEnable;
        end else if (!m0_waitRequest) begin
            m0_read  <= 1'b0;
            m0_write <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_burst_adapter.sv
// Directed bench for cache_burst_adapter: a queue-based transaction model plus a
// latency-configurable single-word slave, checked by one negedge compare process.
module tb_cache_burst_adapter;
    localparam int BURST_W     = 8;
    localparam int MAX_PENDING = 4;

    logic               clk = 1'b0;
    logic               rest = 1'b0;
    logic [31:0]        s0_address = '0;
    logic [3:0]         s0_byteEnable = '0;
    logic               s0_read = 1'b0;
    logic               s0_write = 1'b0;
    logic [31:0]        s0_writeData = '0;
    logic               s0_beginBurstTransfer = 1'b0;
    logic [BURST_W-1:0] s0_burstCount = '0;
    logic               s0_waitRequest;
    logic [31:0]        s0_readData;
    logic               s0_readDataValid;
    logic [31:0]        m0_address;
    logic [3:0]         m0_byteEnable;
    logic               m0_read;
    logic               m0_write;
    logic [31:0]        m0_writeData;
    logic               m0_waitRequest = 1'b0;
    logic [31:0]        m0_readData = '0;
    logic               m0_readDataValid = 1'b0;

    always #5 clk = ~clk;

    cache_burst_adapter #(.BURST_W(BURST_W), .MAX_PENDING(MAX_PENDING)) dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writeData(s0_writeData),
        .s0_beginBurstTransfer(s0_beginBurstTransfer), .s0_burstCount(s0_burstCount),
        .s0_waitRequest(s0_waitRequest), .s0_readData(s0_readData),
        .s0_readDataValid(s0_readDataValid),
        .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writeData(m0_writeData), .m0_waitRequest(m0_waitRequest),
        .m0_readData(m0_readData), .m0_readDataValid(m0_readDataValid)
    );

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } xact_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    xact_t       exp_m0[$];
    logic [31:0] exp_s0[$];
    int          rsp_due[$];
    logic [31:0] rsp_addr[$];
    int          latency = 1;
    int          outstanding = 0;
    int          peak = 0;
    int          rsp_total = 0;
    int          wr_hs_count = 0;
    int          rd_hs_cycle[$];
    logic [31:0] rd_hs_addr[$];
    int          s0_valid_cycle[$];
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic expect_m0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        xact_t t;
        t.is_write = w;
        t.addr     = a;
        t.data     = d;
        t.be       = b;
        exp_m0.push_back(t);
    endtask

    task automatic clear_log();
        rd_hs_cycle.delete();
        rd_hs_addr.delete();
        s0_valid_cycle.delete();
        wr_hs_count = 0;
        peak = 0;
    endtask

    // Slave stall: hold off a specific write address for a programmed number of cycles.
    always @(posedge clk) begin
        #1;
        if (m0_write && m0_address == stall_addr && stall_left > 0) begin
            m0_waitRequest = 1'b1;
            stall_left--;
        end else begin
            m0_waitRequest = 1'b0;
        end
    end

    // Slave responses, handshake accounting and all per-cycle comparisons.
    always @(negedge clk) begin
        xact_t e;
        if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
            m0_readDataValid = 1'b1;
            m0_readData      = mem_word(rsp_addr[0]);
            void'(rsp_due.pop_front());
            void'(rsp_addr.pop_front());
            rsp_total++;
            if (outstanding > 0) outstanding--;
        end else begin
            m0_readDataValid = 1'b0;
            m0_readData      = '0;
        end
        if (m0_read && !m0_waitRequest) begin
            rd_hs_cycle.push_back(cyc);
            rd_hs_addr.push_back(m0_address);
            rsp_due.push_back(cyc + latency);
            rsp_addr.push_back(m0_address);
            outstanding++;
            if (outstanding > peak) peak = outstanding;
            check_output("pending_bound", 32'(outstanding <= MAX_PENDING), 1);
            if (exp_m0.size() == 0) begin
                report_fail("m0_read_unexpected");
            end else begin
                e = exp_m0.pop_front();
                check_output("m0_rd_kind", 32'(e.is_write), 0);
                check_output("m0_rd_addr", m0_address, e.addr);
                check_output("m0_rd_be", 32'(m0_byteEnable), 32'(e.be));
            end
        end
        if (m0_write && !m0_waitRequest) begin
            wr_hs_count++;
            if (exp_m0.size() == 0) begin
                report_fail("m0_write_unexpected");
            end else begin
                e = exp_m0.pop_front();
                check_output("m0_wr_kind", 32'(e.is_write), 1);
                check_output("m0_wr_addr", m0_address, e.addr);
                check_output("m0_wr_data", m0_writeData, e.data);
                check_output("m0_wr_be", 32'(m0_byteEnable), 32'(e.be));
            end
        end
        if (m0_read && m0_write) report_fail("m0_read_and_write");
        if (s0_readDataValid) begin
            s0_valid_cycle.push_back(cyc);
            if (exp_s0.size() == 0) begin
                report_fail("s0_rdata_unexpected");
            end else begin
                check_output("s0_rdata", s0_readData, exp_s0.pop_front());
            end
        end
    end

    task automatic wait_accept(output int acc, output int waits);
        acc   = -1;
        waits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!s0_waitRequest) begin
                acc = cyc;
                break;
            end
            waits++;
        end
        if (acc < 0) report_fail("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic apply_read(input logic [31:0] addr, input int count, output int acc);
        int words;
        int waits;
        words = (count == 0) ? 1 : count;
        for (int i = 0; i < words; i++) begin
            expect_m0(1'b0, {addr[31:2], 2'b00} + 32'(4 * i), 32'h0, 4'hF);
            exp_s0.push_back(mem_word({addr[31:2], 2'b00} + 32'(4 * i)));
        end
        s0_address    = addr;
        s0_burstCount = BURST_W'(count);
        s0_read       = 1'b1;
        wait_accept(acc, waits);
        s0_read = 1'b0;
    endtask

    task automatic write_beat(input logic [31:0] addr, input int count, input logic [31:0] data,
                              input logic [3:0] be, output int waits);
        int acc;
        s0_address    = addr;
        s0_burstCount = BURST_W'(count);
        s0_writeData  = data;
        s0_byteEnable = be;
        s0_write      = 1'b1;
        wait_accept(acc, waits);
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_m0.size() == 0 && exp_s0.size() == 0 && !s0_waitRequest && !m0_read && !m0_write) break;
        end
        check_output({name, "_drained"}, 32'(i < 400), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_m0_read"}, 32'(m0_read), 0);
        check_output({tag, "_m0_write"}, 32'(m0_write), 0);
        check_output({tag, "_m0_address"}, m0_address, 0);
        check_output({tag, "_m0_be"}, 32'(m0_byteEnable), 0);
        check_output({tag, "_m0_wdata"}, m0_writeData, 0);
        check_output({tag, "_s0_rvalid"}, 32'(s0_readDataValid), 0);
        check_output({tag, "_s0_rdata"}, s0_readData, 0);
        check_output({tag, "_s0_wait"}, 32'(s0_waitRequest), 1);
    endtask

    initial begin
        int acc, wacc, waits, rsp0, val0;
        logic [31:0] wdata[3];
        logic [3:0]  wbe[3];
        int          expected_waits[3];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("init");
        @(posedge clk);
        #1;
        rest = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] read burst 0x1000 x4, latency 1");
        latency = 1;
        clear_log();
        apply_read(32'h0000_1000, 4, acc);
        wait_drain("t1");
        check_output("t1_reads", 32'(rd_hs_cycle.size()), 4);
        check_output("t1_valids", 32'(s0_valid_cycle.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_hs_cycle.size()) begin
                check_output("t1_req_cycle", 32'(rd_hs_cycle[i]), 32'(acc + 1 + i));
                check_output("t1_req_addr", rd_hs_addr[i], 32'h0000_1000 + 32'(4 * i));
            end
            if (i < s0_valid_cycle.size()) begin
                check_output("t1_rvalid_cycle", 32'(s0_valid_cycle[i]), 32'(acc + 3 + i));
            end
        end
        check_output("t1_mem_pin", mem_word(32'h0000_1000), 32'h1000_EFFF);

        $display("[TB] read burst x8, latency 10");
        latency = 10;
        clear_log();
        apply_read(32'h0000_3000, 8, acc);
        wait_drain("t2");
        check_output("t2_peak", 32'(peak), 4);
        check_output("t2_valids", 32'(s0_valid_cycle.size()), 8);
        latency = 1;

        $display("[TB] write burst 0x2002 x3 with stall on beat 2");
        clear_log();
        wdata          = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        wbe            = '{4'b1111, 4'b0011, 4'b1100};
        expected_waits = '{0, 0, 2};
        stall_addr     = 32'h0000_2004;
        stall_left     = 2;
        for (int i = 0; i < 3; i++) begin
            expect_m0(1'b1, 32'h0000_2000 + 32'(4 * i), wdata[i], wbe[i]);
        end
        for (int i = 0; i < 3; i++) begin
            write_beat(32'h0000_2002, 3, wdata[i], wbe[i], waits);
            check_output("t3_beat_waits", 32'(waits), 32'(expected_waits[i]));
        end
        s0_write = 1'b0;
        wait_drain("t3");
        check_output("t3_writes", 32'(wr_hs_count), 3);
        stall_addr = 32'hFFFF_FFFF;

        $display("[TB] count-0 and count-2 reads at top of address space");
        clear_log();
        apply_read(32'hFFFF_FFFC, 0, acc);
        wait_drain("t4a");
        check_output("t4a_reads", 32'(rd_hs_addr.size()), 1);
        if (rd_hs_addr.size() > 0) check_output("t4a_addr", rd_hs_addr[0], 32'hFFFF_FFFC);
        clear_log();
        apply_read(32'hFFFF_FFFC, 2, acc);
        wait_drain("t4b");
        check_output("t4b_reads", 32'(rd_hs_addr.size()), 2);
        if (rd_hs_addr.size() > 1) begin
            check_output("t4b_addr0", rd_hs_addr[0], 32'hFFFF_FFFC);
            check_output("t4b_addr1", rd_hs_addr[1], 32'h0000_0000);
        end

        $display("[TB] simultaneous read and write in idle");
        clear_log();
        expect_m0(1'b0, 32'h0000_6000, 32'h0, 4'hF);
        exp_s0.push_back(mem_word(32'h0000_6000));
        expect_m0(1'b1, 32'h0000_6000, 32'h600D_F00D, 4'b0110);
        s0_address    = 32'h0000_6000;
        s0_burstCount = BURST_W'(1);
        s0_writeData  = 32'h600D_F00D;
        s0_byteEnable = 4'b0110;
        s0_read       = 1'b1;
        s0_write      = 1'b1;
        wait_accept(acc, waits);
        s0_read = 1'b0;
        wait_accept(wacc, waits);
        s0_write = 1'b0;
        wait_drain("t6");
        check_output("t6_write_held", 32'(waits >= 1), 1);
        check_output("t6_valids", 32'(s0_valid_cycle.size()), 1);
        if (s0_valid_cycle.size() > 0) check_output("t6_read_first", 32'(s0_valid_cycle[0] < wacc), 1);
        check_output("t6_writes", 32'(wr_hs_count), 1);

        $display("[TB] reset mid read burst, late data after release");
        latency = 6;
        clear_log();
        apply_read(32'h0000_4000, 4, acc);
        @(posedge clk);
        #1;
        rest = 1'b0;
        @(posedge clk);
        #1;
        exp_m0.delete();
        exp_s0.delete();
        outstanding = 0;
        check_output("t5_issued_before_reset", 32'(rd_hs_cycle.size()), 2);
        @(negedge clk);
        check_reset_values("t5");
        @(posedge clk);
        #1;
        rest = 1'b1;
        rsp0 = rsp_total;
        val0 = s0_valid_cycle.size();
        repeat (10) @(posedge clk);
        #1;
        check_output("t5_late_data_seen", 32'(rsp_total - rsp0), 2);
        check_output("t5_late_data_dropped", 32'(s0_valid_cycle.size() - val0), 0);
        latency = 1;
        clear_log();
        apply_read(32'h0000_5000, 2, acc);
        wait_drain("t5_recover");
        check_output("t5_recover_valids", 32'(s0_valid_cycle.size()), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
